// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath and its downstream accumulator.
// Holds the product width, the accumulator state encoding and a width helper.
package mult_pkg;

    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_e;

    // Ceiling log2, usable in constant expressions for counter widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/dot_product_accumulator.sv
// Sums each group of VEC_LEN unsigned products from the multiplier and presents
// the registered dot product plus a sticky overflow flag on a valid/ready port.
module dot_product_accumulator
    import mult_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy
);

    localparam int CNT_W = clog2(VEC_LEN + 1);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(VEC_LEN);

    if (VEC_LEN < 2 || VEC_LEN > 256 || ACC_W < 16 || ACC_W > 32) begin : g_param_check
        $error("dot_product_accumulator: VEC_LEN must be 2..256 and ACC_W 16..32");
    end

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             flush_abort;
    logic             accept;
    logic [SUM_W-1:0] sum_wide;
    logic [CNT_W-1:0] count_inc;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        flush_abort = flush && (state_q == ACCUM);
        in_ready    = ((state_q != HOLD) || out_ready) && !flush_abort;
        accept      = in_valid && in_ready;
        sum_wide    = {1'b0, acc_q} + SUM_W'(in_product);
        count_inc   = count_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = ACC_W'(in_product);
                    ovf_d   = 1'b0;
                    count_d = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (flush_abort) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    acc_d   = sum_wide[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_wide[ACC_W];
                    count_d = count_inc;
                    if (count_inc == LAST_COUNT) begin
                        out_sum_d = sum_wide[ACC_W-1:0];
                        out_ovf_d = ovf_q | sum_wide[ACC_W];
                        count_d   = '0;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                // Consuming the result and starting the next vector share one edge.
                if (out_ready) begin
                    if (accept) begin
                        acc_d   = ACC_W'(in_product);
                        ovf_d   = 1'b0;
                        count_d = CNT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d == ACCUM);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_ovf_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench: two accumulators (24-bit and 16-bit) share one input stream;
// a vector-total model feeds per-instance queues that monitors drain on handshakes.
module tb_dot_product_accumulator;

    localparam int VEC_LEN = 8;
    localparam int W_A     = 24;
    localparam int W_B     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_product = '0;
    logic        flush = 1'b0;
    logic        dir_ready = 1'b1;
    logic        rand_ready = 1'b1;
    logic        rand_mode = 1'b0;
    logic        out_ready;

    logic           in_ready_a, out_valid_a, ovf_a, busy_a;
    logic           in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [W_A-1:0] sum_a;
    logic [W_B-1:0] sum_b;

    assign out_ready = rand_mode ? rand_ready : dir_ready;

    dot_product_accumulator #(.VEC_LEN(VEC_LEN), .ACC_W(W_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_product(in_product), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(sum_a), .out_overflow(ovf_a), .busy(busy_a)
    );

    dot_product_accumulator #(.VEC_LEN(VEC_LEN), .ACC_W(W_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_product(in_product), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(sum_b), .out_overflow(ovf_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint q_a[$];
    longint q_b[$];
    longint cur_total = 0;
    int     cur_cnt = 0;
    int     stalls = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: full-precision total per vector; width effects applied at compare.
    task automatic model_accept(input logic [15:0] p);
        cur_total += longint'(p);
        cur_cnt++;
        if (cur_cnt == VEC_LEN) begin
            q_a.push_back(cur_total);
            q_b.push_back(cur_total);
            cur_total = 0;
            cur_cnt   = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the product is accepted.
    task automatic send(input logic [15:0] p);
        int budget;
        bit taken;
        budget = 0;
        taken  = 1'b0;
        in_valid   = 1'b1;
        in_product = p;
        while (!taken && budget < 50) begin
            @(negedge clk);
            taken = in_ready_a;
            if (in_ready_b !== in_ready_a) check("in_ready_match", in_ready_b, in_ready_a);
            @(posedge clk);
            #1;
            if (!taken) begin
                stalls++;
                budget++;
            end
        end
        in_valid = 1'b0;
        if (taken) model_accept(p);
        else check("send_timeout", {63'd0, taken}, 64'd1);
    endtask

    task automatic do_flush();
        bit was_accum;
        was_accum = (cur_cnt > 0);
        flush    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        if (was_accum) check("flush_in_ready", in_ready_a, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (was_accum) begin
            cur_total = 0;
            cur_cnt   = 0;
            check("flush_busy", busy_a, 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        rand_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor for the 24-bit instance, including stability of a stalled result.
    bit             stalled_a = 1'b0;
    logic [W_A-1:0] held_sum_a;
    logic           held_ovf_a;
    always @(negedge clk) begin
        longint t;
        if (rst_n && out_valid_a) begin
            if (stalled_a) begin
                check("hold_sum_a", sum_a, held_sum_a);
                check("hold_ovf_a", ovf_a, held_ovf_a);
            end
            if (out_ready) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result_a: got sum 0x%0h, expected no result at %0t", sum_a, $time);
                end else begin
                    t = q_a.pop_front();
                    check("sum_a", sum_a, t & ((64'd1 << W_A) - 1));
                    check("ovf_a", ovf_a, 64'((t >> W_A) != 0));
                end
            end
        end
        stalled_a  = rst_n && out_valid_a && !out_ready;
        held_sum_a = sum_a;
        held_ovf_a = ovf_a;
    end

    always @(negedge clk) begin
        longint t;
        if (rst_n && out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result_b: got sum 0x%0h, expected no result at %0t", sum_b, $time);
            end else begin
                t = q_b.pop_front();
                check("sum_b", sum_b, t & ((64'd1 << W_B) - 1));
                check("ovf_b", ovf_b, 64'((t >> W_B) != 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;
        dir_ready = 1'b1;
        #12;
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_sum_a", sum_a, 0);
        check("rst_ovf_a", ovf_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_in_ready_a", in_ready_a, 1);
        check("rst_out_valid_b", out_valid_b, 0);
        check("rst_in_ready_b", in_ready_b, 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Basic sum 1..8 with latency and busy checks.
        for (int i = 1; i <= VEC_LEN; i++) begin
            send(16'(i));
            if (i == 1) check("busy_after_first", busy_a, 1);
            if (i == VEC_LEN - 1) check("no_early_valid", out_valid_a, 0);
        end
        check("latency_out_valid", out_valid_a, 1);
        check("busy_at_complete", busy_a, 0);
        idle(2);
        check("idle_after_consume", out_valid_a, 0);

        // Maximum products: no overflow at 24 bits, overflow at 16 bits.
        for (int i = 0; i < VEC_LEN; i++) send(16'hFE01);
        idle(2);

        // Backpressure for 5 cycles, then 16 products back-to-back.
        dir_ready = 1'b0;
        for (int i = 0; i < VEC_LEN; i++) send(16'($urandom));
        in_valid   = 1'b1;
        in_product = 16'h1234;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready_a, 0);
            check("bp_out_valid", out_valid_a, 1);
            @(posedge clk);
            #1;
        end
        dir_ready = 1'b1;
        stalls = 0;
        send(16'h1234);
        for (int i = 1; i < 2 * VEC_LEN; i++) send(16'($urandom));
        check("no_bubble_stalls", stalls, 0);
        idle(2);

        // Flush mid-vector, then a clean vector of ones.
        send(16'd10);
        send(16'd20);
        send(16'd30);
        do_flush();
        for (int i = 0; i < VEC_LEN; i++) send(16'd1);
        idle(2);

        // Flush while a result is held is ignored.
        dir_ready = 1'b0;
        for (int i = 0; i < VEC_LEN; i++) send(16'($urandom));
        do_flush();
        @(negedge clk);
        check("hold_flush_valid", out_valid_a, 1);
        @(posedge clk);
        #1;
        dir_ready = 1'b1;
        idle(2);

        // Reset mid-vector.
        for (int i = 0; i < 4; i++) send(16'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid_a, 0);
        check("mid_rst_sum", sum_a, 0);
        check("mid_rst_ovf", ovf_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_in_ready", in_ready_a, 1);
        cur_total = 0;
        cur_cnt   = 0;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < VEC_LEN; i++) send(16'd2);
        idle(2);

        // Randomised traffic with random backpressure, gaps and flushes.
        rand_mode = 1'b1;
        repeat (300) begin
            int r;
            r = $urandom_range(0, 29);
            if (r == 0) do_flush();
            else if (r < 5) idle(1);
            else send(16'($urandom));
        end
        rand_mode = 1'b0;

        budget = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && budget < 100) begin
            idle(1);
            budget++;
        end
        check("drain_q_a", q_a.size(), 0);
        check("drain_q_b", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
